// File: rtl/accel_pkg.sv
// Shared defaults and FSM encoding for the FM-index accelerator task loader.
package accel_pkg;

   localparam int ADDR_W_DEF      = 12;
   localparam int IR_W_DEF        = 32;
   localparam int ST_W_DEF        = 18;
   localparam int MAX_ENTRIES_DEF = 4096;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      RUN    = 3'd3,
      FIN    = 3'd4
   } loader_state_e;

endpackage

// File: rtl/accel_task_loader_if.sv
// Valid/ready task-entry stream: producer is master, loader is slave.
interface accel_task_loader_if #(
   parameter int IR_W = accel_pkg::IR_W_DEF,
   parameter int ST_W = accel_pkg::ST_W_DEF
);
   logic            s_valid;
   logic            s_ready;
   logic [IR_W-1:0] s_ir_data;
   logic [ST_W-1:0] s_st_data;
   logic            s_last;

   modport master (output s_valid, output s_ir_data, output s_st_data, output s_last,
                   input  s_ready);
   modport slave  (input  s_valid, input  s_ir_data, input  s_st_data, input  s_last,
                   output s_ready);
endinterface

// File: rtl/accel_load_wr_stage.sv
// Registered regfile write stage: an accepted entry becomes a write one cycle later.
module accel_load_wr_stage
   import accel_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int IR_W        = IR_W_DEF,
   parameter int ST_W        = ST_W_DEF,
   parameter int MAX_ENTRIES = MAX_ENTRIES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              accept,
   input  logic [IR_W-1:0]   ir_in,
   input  logic [ST_W-1:0]   st_in,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [IR_W-1:0]   ir_out,
   output logic [ST_W-1:0]   st_out,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W:0]   entry_count
);

   localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(MAX_ENTRIES);

   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic [ST_W-1:0]   st_q, st_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   // wr_ptr advances at the accept edge so back-to-back accepts get contiguous addresses.
   always_comb begin
      we_d     = accept;
      addr_d   = addr_q;
      ir_d     = ir_q;
      st_d     = st_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (accept) begin
         addr_d   = wr_ptr_q;
         ir_d     = ir_in;
         st_d     = st_in;
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (we_q && (cnt_q < CNT_MAX)) begin
         cnt_d = cnt_q + (ADDR_W+1)'(1);
      end
      if (clr) begin
         wr_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         ir_q     <= '0;
         st_q     <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         we_q     <= we_d;
         addr_q   <= addr_d;
         ir_q     <= ir_d;
         st_q     <= st_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign we          = we_q;
   assign addr        = addr_q;
   assign ir_out      = ir_q;
   assign st_out      = st_q;
   assign wr_ptr      = wr_ptr_q;
   assign entry_count = cnt_q;

endmodule

// File: rtl/accel_task_loader.sv
// Loads task entries into the InexRecur/state regfiles, then runs the accelerator until done.
module accel_task_loader
   import accel_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int IR_W        = IR_W_DEF,
   parameter int ST_W        = ST_W_DEF,
   parameter int MAX_ENTRIES = MAX_ENTRIES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   accel_task_loader_if.slave s,
   input  logic              load_req,
   output logic              ran_we_InexRecur,
   output logic [ADDR_W-1:0] ran_w_addr_InexRecur,
   output logic [IR_W-1:0]   ran_w_data_InexRecur,
   output logic              ran_we_state_external,
   output logic [ADDR_W-1:0] ran_w_addr_state_external,
   output logic [ST_W-1:0]   ran_w_data_state_external,
   output logic              is_start,
   input  logic              acc_done,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   entry_count,
   output logic              overflow_err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ENTRIES - 1);

   loader_state_e     state_q, state_d;
   logic              ovf_q, ovf_d;
   logic              clr;
   logic              accept;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] wr_ptr;

   assign s.s_ready = (state_q == LOAD);
   assign accept    = s.s_valid && s.s_ready;

   always_comb begin
      state_d = state_q;
      ovf_d   = ovf_q;
      clr     = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_req) begin
               clr     = 1'b1;
               ovf_d   = 1'b0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               if (s.s_last) begin
                  state_d = SETTLE;
               end else if (wr_ptr == LAST_ADDR) begin
                  state_d = SETTLE;
                  ovf_d   = 1'b1;
               end
            end
         end
         // The last write lands here, while is_start is still low.
         SETTLE:  state_d = RUN;
         RUN:     if (acc_done) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
      end
   end

   accel_load_wr_stage #(
      .ADDR_W      (ADDR_W),
      .IR_W        (IR_W),
      .ST_W        (ST_W),
      .MAX_ENTRIES (MAX_ENTRIES)
   ) u_wr (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .accept      (accept),
      .ir_in       (s.s_ir_data),
      .st_in       (s.s_st_data),
      .we          (we),
      .addr        (addr),
      .ir_out      (ran_w_data_InexRecur),
      .st_out      (ran_w_data_state_external),
      .wr_ptr      (wr_ptr),
      .entry_count (entry_count)
   );

   assign ran_we_InexRecur          = we;
   assign ran_we_state_external     = we;
   assign ran_w_addr_InexRecur      = addr;
   assign ran_w_addr_state_external = addr;
   assign is_start                  = (state_q == RUN);
   assign done                      = (state_q == FIN);
   assign busy                      = (state_q != IDLE);
   assign overflow_err              = ovf_q;

endmodule

// File: tb/tb_accel_task_loader.sv
// Directed bench for accel_task_loader (MAX_ENTRIES=8 so overflow is reachable).
module tb_accel_task_loader;
   localparam int ADDR_W = 12;
   localparam int IR_W   = 32;
   localparam int ST_W   = 18;
   localparam int MAXE   = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              load_req;
   logic              acc_done;
   logic              we_ir, we_st;
   logic [ADDR_W-1:0] addr_ir, addr_st;
   logic [IR_W-1:0]   data_ir;
   logic [ST_W-1:0]   data_st;
   logic              is_start, busy, done, overflow_err;
   logic [ADDR_W:0]   entry_count;

   int total = 0;
   int bad   = 0;
   int viol  = 0;
   int pairbad = 0;
   int          log_addr[$];
   logic [31:0] log_ir[$];
   logic [31:0] log_st[$];

   accel_task_loader_if #(.IR_W(IR_W), .ST_W(ST_W)) sif ();

   accel_task_loader #(
      .ADDR_W(ADDR_W), .IR_W(IR_W), .ST_W(ST_W), .MAX_ENTRIES(MAXE)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .s                         (sif),
      .load_req                  (load_req),
      .ran_we_InexRecur          (we_ir),
      .ran_w_addr_InexRecur      (addr_ir),
      .ran_w_data_InexRecur      (data_ir),
      .ran_we_state_external     (we_st),
      .ran_w_addr_state_external (addr_st),
      .ran_w_data_state_external (data_st),
      .is_start                  (is_start),
      .acc_done                  (acc_done),
      .busy                      (busy),
      .done                      (done),
      .entry_count               (entry_count),
      .overflow_err              (overflow_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we_ir === 1'b1) begin
         log_addr.push_back(int'(addr_ir));
         log_ir.push_back(data_ir);
         log_st.push_back(32'(data_st));
      end
      if ((we_ir === 1'b1 || we_st === 1'b1) && is_start === 1'b1) viol++;
      if (we_ir !== we_st || (we_ir === 1'b1 && (addr_ir !== addr_st))) pairbad++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_ir.delete();
      log_st.delete();
   endtask

   task automatic finish_run();
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      tick();
   endtask

   task automatic load_one(input logic [31:0] ir);
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      sif.s_valid = 1'b1; sif.s_ir_data = ir; sif.s_st_data = 18'd9; sif.s_last = 1'b1;
      tick();
      sif.s_valid = 1'b0; sif.s_last = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; load_req = 1'b0; acc_done = 1'b0;
      sif.s_valid = 1'b0; sif.s_ir_data = '0; sif.s_st_data = '0; sif.s_last = 1'b0;
      tick(); tick();
      total++;
      if ({we_ir, we_st, is_start, busy, done, sif.s_ready, overflow_err} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {we_ir, we_st, is_start, busy, done, sif.s_ready, overflow_err});
      end
      total++;
      if (addr_ir !== '0 || addr_st !== '0 || data_ir !== '0 || data_st !== '0 || entry_count !== '0) begin
         bad++;
         $display("FAIL reset_data: addr %0h/%0h data %0h/%0h cnt %0d want all 0",
                  addr_ir, addr_st, data_ir, data_st, entry_count);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [31:0] irs [3];
      irs[0] = 32'h11; irs[1] = 32'h22; irs[2] = 32'h33;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      total++;
      if (sif.s_ready !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL basic_load_state: s_ready=%b busy=%b want 1 1", sif.s_ready, busy);
      end
      for (int i = 0; i < 3; i++) begin
         sif.s_valid = 1'b1; sif.s_ir_data = irs[i]; sif.s_st_data = 18'(i + 1);
         sif.s_last = (i == 2);
         tick();
         total++;
         if (we_ir !== 1'b1 || addr_ir !== ADDR_W'(i) || data_ir !== irs[i] || data_st !== 18'(i + 1)) begin
            bad++;
            $display("FAIL basic_write%0d: we=%b addr=%0d ir=%0h st=%0d want 1 %0d %0h %0d",
                     i, we_ir, addr_ir, data_ir, data_st, i, irs[i], i + 1);
         end
      end
      sif.s_valid = 1'b0; sif.s_last = 1'b0;
      total++;
      if (sif.s_ready !== 1'b0 || is_start !== 1'b0) begin
         bad++;
         $display("FAIL basic_settle: s_ready=%b is_start=%b want 0 0", sif.s_ready, is_start);
      end
      tick();
      total++;
      if (is_start !== 1'b1 || entry_count !== 13'd3 || overflow_err !== 1'b0 || we_ir !== 1'b0) begin
         bad++;
         $display("FAIL basic_run: is_start=%b cnt=%0d ovf=%b we=%b want 1 3 0 0",
                  is_start, entry_count, overflow_err, we_ir);
      end
   endtask

   task automatic test_run_done();
      int low = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (is_start !== 1'b1 || done !== 1'b0) low++;
      end
      total++;
      if (low !== 0) begin
         bad++;
         $display("FAIL run_hold: cycles without is_start=%0d want 0", low);
      end
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      total++;
      if (done !== 1'b1 || is_start !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL run_fin: done=%b is_start=%b busy=%b want 1 0 1", done, is_start, busy);
      end
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL run_idle: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_stalls();
      clear_log();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      sif.s_valid = 1'b1; sif.s_ir_data = 32'hA1; sif.s_st_data = 18'd5; sif.s_last = 1'b0;
      tick();
      sif.s_valid = 1'b0;
      tick(); tick();
      sif.s_valid = 1'b1; sif.s_ir_data = 32'hA2; sif.s_st_data = 18'd6; sif.s_last = 1'b1;
      tick();
      sif.s_valid = 1'b0; sif.s_last = 1'b0;
      tick(); tick();
      total++;
      if (log_addr.size() !== 2) begin
         bad++;
         $display("FAIL stall_count: writes=%0d want 2", log_addr.size());
      end else begin
         total++;
         if (log_addr[0] !== 0 || log_ir[0] !== 32'hA1 || log_st[0] !== 32'd5 ||
             log_addr[1] !== 1 || log_ir[1] !== 32'hA2 || log_st[1] !== 32'd6) begin
            bad++;
            $display("FAIL stall_data: %0d:%0h/%0h %0d:%0h/%0h want 0:a1/5 1:a2/6",
                     log_addr[0], log_ir[0], log_st[0], log_addr[1], log_ir[1], log_st[1]);
         end
      end
      total++;
      if (is_start !== 1'b1 || entry_count !== 13'd2) begin
         bad++;
         $display("FAIL stall_run: is_start=%b cnt=%0d want 1 2", is_start, entry_count);
      end
      finish_run();
   endtask

   task automatic test_overflow();
      int acc = 0;
      int errs = 0;
      logic rdy;
      logic chk8 = 1'b0;
      clear_log();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sif.s_valid = 1'b1; sif.s_ir_data = 32'h100 + 32'(i); sif.s_st_data = 18'(i);
         sif.s_last = 1'b0;
         rdy = sif.s_ready;
         tick();
         if (rdy === 1'b1) acc++;
         if (acc == 8 && !chk8) begin
            chk8 = 1'b1;
            total++;
            if (sif.s_ready !== 1'b0) begin
               bad++;
               $display("FAIL ovf_ready: s_ready=%b after 8th accept want 0", sif.s_ready);
            end
         end
      end
      sif.s_valid = 1'b0;
      tick(); tick();
      total++;
      if (acc !== 8 || log_addr.size() !== 8) begin
         bad++;
         $display("FAIL ovf_count: accepts=%0d writes=%0d want 8 8", acc, log_addr.size());
      end else begin
         for (int i = 0; i < 8; i++)
            if (log_addr[i] !== i || log_ir[i] !== 32'h100 + 32'(i) || log_st[i] !== 32'(i)) errs++;
         total++;
         if (errs !== 0) begin
            bad++;
            $display("FAIL ovf_data: bad entries=%0d want 0", errs);
         end
      end
      total++;
      if (overflow_err !== 1'b1 || entry_count !== 13'd8 || is_start !== 1'b1) begin
         bad++;
         $display("FAIL ovf_flags: ovf=%b cnt=%0d is_start=%b want 1 8 1",
                  overflow_err, entry_count, is_start);
      end
      finish_run();
      total++;
      if (overflow_err !== 1'b1 || entry_count !== 13'd8) begin
         bad++;
         $display("FAIL ovf_sticky: ovf=%b cnt=%0d want 1 8", overflow_err, entry_count);
      end
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      total++;
      if (overflow_err !== 1'b0 || entry_count !== 13'd0) begin
         bad++;
         $display("FAIL ovf_clear: ovf=%b cnt=%0d want 0 0", overflow_err, entry_count);
      end
      sif.s_valid = 1'b1; sif.s_ir_data = 32'h55; sif.s_last = 1'b1;
      tick();
      sif.s_valid = 1'b0; sif.s_last = 1'b0;
      tick(); tick();
      finish_run();
   endtask

   task automatic test_reset_mid();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      sif.s_valid = 1'b1; sif.s_ir_data = 32'h77; sif.s_st_data = 18'd7; sif.s_last = 1'b0;
      tick();
      sif.s_ir_data = 32'h78;
      tick();
      sif.s_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({we_ir, we_st, is_start, busy, done, sif.s_ready, overflow_err} !== 7'b0 ||
          addr_ir !== '0 || data_ir !== '0 || data_st !== '0 || entry_count !== '0) begin
         bad++;
         $display("FAIL rst_load: ctrl=%b addr=%0d ir=%0h st=%0h cnt=%0d want all 0",
                  {we_ir, we_st, is_start, busy, done, sif.s_ready, overflow_err},
                  addr_ir, data_ir, data_st, entry_count);
      end
      clear_log();
      load_one(32'h99);
      total++;
      if (log_addr.size() !== 1 || log_addr[0] !== 0 || log_ir[0] !== 32'h99 || is_start !== 1'b1) begin
         bad++;
         $display("FAIL rst_reload: writes=%0d is_start=%b want 1 write at addr 0 data 99, is_start 1",
                  log_addr.size(), is_start);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (is_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || entry_count !== '0) begin
         bad++;
         $display("FAIL rst_run: is_start=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
                  is_start, busy, done, entry_count);
      end
      tick();
   endtask

   task automatic test_ignored();
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL ign_done_idle: busy=%b done=%b want 0 0", busy, done);
      end
      tick();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL ign_done_late: done=%b want 0", done);
      end
      load_one(32'h42);
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      total++;
      if (is_start !== 1'b1 || busy !== 1'b1 || sif.s_ready !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL ign_load_run: is_start=%b busy=%b s_ready=%b done=%b want 1 1 0 0",
                  is_start, busy, sif.s_ready, done);
      end
      finish_run();
   endtask

   task automatic test_integrity();
      total++;
      if (viol !== 0) begin
         bad++;
         $display("FAIL we_during_start: count=%0d want 0", viol);
      end
      total++;
      if (pairbad !== 0) begin
         bad++;
         $display("FAIL we_pair: count=%0d want 0", pairbad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_run_done();
      test_stalls();
      test_overflow();
      test_reset_mid();
      test_ignored();
      test_integrity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/accel_task_loader.md
Name: accel_task_loader

Overview:
- Upstream stage of the FM-index search accelerator.
- Accepts a valid/ready stream of task entries; each entry is one InexRecur word plus one state word.
- Writes each entry into the InexRecur and state regfiles through their random-write load ports, at consecutive addresses from 0.
- Then raises is_start and holds it until the accelerator reports completion. It holds is_start low during loading, because the state-regfile write port is only routed to the load side while is_start is low.

Parameters:
- ADDR_W, 12, regfile address width.
- IR_W, 32, InexRecur word width.
- ST_W, 18, state word width.
- MAX_ENTRIES, 4096, regfile depth; the last legal address is MAX_ENTRIES-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_req  in  1  one-cycle request to start a load; only honoured in IDLE
- s_valid  in  1  entry valid
- s_ready  out  1  loader can accept an entry
- s_ir_data  in  IR_W  InexRecur word
- s_st_data  in  ST_W  state word
- s_last  in  1  marks the final entry of the batch
- ran_we_InexRecur  out  1  InexRecur regfile write enable
- ran_w_addr_InexRecur  out  ADDR_W  InexRecur write address
- ran_w_data_InexRecur  out  IR_W  InexRecur write data
- ran_we_state_external  out  1  state regfile write enable
- ran_w_addr_state_external  out  ADDR_W  state write address
- ran_w_data_state_external  out  ST_W  state write data
- is_start  out  1  accelerator run enable
- acc_done  in  1  accelerator completion pulse
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a run finishes
- entry_count  out  ADDR_W+1  number of entries written in the last load
- overflow_err  out  1  sticky flag: batch was truncated at MAX_ENTRIES

Behaviour:
- Reset values (rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: s_ready, both write enables, both write addresses and data, is_start, busy, done, entry_count, overflow_err.
  - The write pointer wr_ptr is 0.
  - Reset in any state aborts immediately; is_start drops on the next edge.
- States: IDLE, LOAD, SETTLE, RUN, FIN.
- IDLE:
  - On load_req: clear wr_ptr, entry_count and overflow_err; go to LOAD.
  - load_req in any other state is ignored.
- LOAD:
  - s_ready=1, combinational from the state only.
  - Accept rule: an entry is accepted on a cycle with s_valid && s_ready.
  - One cycle after an accept, both write enables are 1 for exactly one cycle.
  - Both write addresses equal wr_ptr; data is the accepted words, registered.
  - Then wr_ptr and entry_count each increment by 1.
  - Back-to-back accepts give one write per cycle with contiguous addresses.
- Leaving LOAD:
  - When s_last is accepted, go to SETTLE.
  - When an accept lands at wr_ptr==MAX_ENTRIES-1 without s_last, also go to SETTLE and set overflow_err=1. It stays set until the next honoured load_req.
- SETTLE: s_ready=0. The final write is performed in this cycle; then go to RUN.
- RUN:
  - is_start=1 from the first RUN cycle, held until acc_done is sampled high.
  - No write enable is ever 1 while is_start=1.
  - On acc_done: go to FIN.
  - acc_done outside RUN is ignored.
- FIN: done=1 and is_start=0 for this one cycle; then go to IDLE.
- Latency:
  - Accept to write: 1 cycle.
  - Accept of the last entry to is_start rise: 2 cycles.
- entry_count counts writes, saturates at MAX_ENTRIES, and holds until the next load_req.
- s_valid in IDLE, SETTLE, RUN or FIN is not accepted (s_ready=0); no data is consumed or lost.

Decomposition:
- Package accel_pkg holds:
  - ADDR_W, IR_W, ST_W and MAX_ENTRIES defaults.
  - The loader state enum (IDLE/LOAD/SETTLE/RUN/FIN).
- One natural sub-module, accel_load_wr_stage: the registered write stage (accept → we/addr/data, with wr_ptr and entry_count). The FSM stays in the top of the block.

Test Plan:
- Basic load: load_req, then 3 back-to-back entries (IR=0x11,0x22,0x33; ST=1,2,3; s_last on the third) → writes at addr 0,1,2 on the 3 cycles after each accept; is_start rises 2 cycles after the third accept; entry_count=3; overflow_err=0.
- Stalls: s_valid toggles 1,0,0,1 with s_last on the second entry → exactly 2 writes at addr 0,1; no write on idle cycles.
- Run/done: in RUN, hold acc_done=0 for 50 cycles then pulse it → is_start is high for all 50 cycles; done pulses 1 cycle later; busy=0 the cycle after that; no write enable is ever seen with is_start=1.
- Overflow: MAX_ENTRIES=8, stream 10 entries with no s_last → 8 writes (addr 0..7); overflow_err=1; entry_count=8; s_ready=0 after the 8th accept; overflow_err clears on the next load_req.
- Mid-operation reset: assert rst during LOAD after 2 writes, and separately during RUN → next cycle all outputs are 0 and state is IDLE; the following load starts again at addr 0.
- Ignored inputs: load_req during RUN, and acc_done during IDLE → no state change; no done pulse.
